// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - push-button debouncer with press strobe and auto-repeat
// Two-flop synchronizer, four-state debounce FSM, saturating hold/repeat timing.

module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 50000,
  parameter int REPEAT_CYCLES   = 10000,
  parameter int REPEAT_EN       = 1,
  parameter int CNT_W           = 17
) (
  input  logic clk,
  input  logic reset,
  input  logic button_raw,
  output logic button_level,
  output logic button_pulse,
  output logic button_held
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic             RPT_ON    = (REPEAT_EN != 0);

  state_t           state;
  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] stab_cnt;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] rep_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1           <= 1'b0;
      s2           <= 1'b0;
      state        <= IDLE;
      stab_cnt     <= '0;
      hold_cnt     <= '0;
      rep_cnt      <= '0;
      button_level <= 1'b0;
      button_pulse <= 1'b0;
      button_held  <= 1'b0;
    end else begin
      s1           <= button_raw;
      s2           <= s1;
      button_pulse <= 1'b0;

      case (state)
        IDLE: begin
          if (s2) begin
            state    <= PRESS_WAIT;
            stab_cnt <= CNT_ONE;
          end
        end

        PRESS_WAIT: begin
          if (!s2) begin
            state    <= IDLE;
            stab_cnt <= '0;
          end else if (stab_cnt == DEB_LAST) begin
            state        <= PRESSED;
            stab_cnt     <= '0;
            hold_cnt     <= '0;
            rep_cnt      <= '0;
            button_level <= 1'b1;
            button_pulse <= 1'b1;
          end else begin
            stab_cnt <= stab_cnt + CNT_ONE;
          end
        end

        PRESSED, RELEASE_WAIT: begin
          if (s2) begin
            // Every high sample while pressed advances the hold timeline, including
            // the one that cancels a release, so a glitch only shifts it by its length.
            state    <= PRESSED;
            stab_cnt <= '0;
            if (hold_cnt != HOLD_MAX) begin
              hold_cnt <= hold_cnt + CNT_ONE;
              if (RPT_ON && hold_cnt == HOLD_LAST) begin
                button_pulse <= 1'b1;
                button_held  <= 1'b1;
                rep_cnt      <= '0;
              end
            end else if (RPT_ON) begin
              if (rep_cnt == REP_LAST) begin
                button_pulse <= 1'b1;
                rep_cnt      <= '0;
              end else if (rep_cnt != '1) begin
                rep_cnt <= rep_cnt + CNT_ONE;
              end
            end
          end else if (state == PRESSED) begin
            state    <= RELEASE_WAIT;
            stab_cnt <= CNT_ONE;
          end else if (stab_cnt == DEB_LAST) begin
            state        <= IDLE;
            stab_cnt     <= '0;
            button_level <= 1'b0;
            button_held  <= 1'b0;
          end else begin
            stab_cnt <= stab_cnt + CNT_ONE;
          end
        end

        default: begin
          state    <= IDLE;
          stab_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - scoreboard bench for button_debouncer
// Driver steps a run-length reference model; monitor pops and compares each cycle.

module tb_button_debouncer;

  localparam int DEB  = 4;
  localparam int HOLD = 20;
  localparam int REP  = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic button_raw = 1'b0;
  logic button_level;
  logic button_pulse;
  logic button_held;

  always #5 clk = ~clk;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEB),
    .HOLD_CYCLES(HOLD),
    .REPEAT_CYCLES(REP),
    .REPEAT_EN(1),
    .CNT_W(17)
  ) dut (
    .clk(clk),
    .reset(reset),
    .button_raw(button_raw),
    .button_level(button_level),
    .button_pulse(button_pulse),
    .button_held(button_held)
  );

  typedef struct {
    int   step;
    logic lvl;
    logic pls;
    logic hld;
  } exp_t;

  exp_t expq[$];
  int   pulse_log[$];
  int   total = 0;
  int   bad = 0;
  int   step = 0;

  // Reference model: sync pipeline as a two-sample delay, debounce as a run
  // length of samples disagreeing with the accepted level, repeat schedule as
  // arithmetic on the time spent pressed.
  logic m_s1 = 1'b0, m_s2 = 1'b0, m_lvl = 1'b0, m_held = 1'b0, m_pls = 1'b0;
  int   m_run = 0;
  int   m_pt = 0;

  task automatic drive(input logic r, input logic rs);
    exp_t e;
    @(negedge clk);
    button_raw = r;
    reset = rs;
    if (rs) begin
      m_s1 = 1'b0; m_s2 = 1'b0; m_lvl = 1'b0; m_held = 1'b0; m_pls = 1'b0;
      m_run = 0; m_pt = 0;
    end else begin
      m_pls = 1'b0;
      if (m_s2 == m_lvl) begin
        m_run = 0;
        if (m_lvl) begin
          m_pt++;
          if (m_pt == HOLD || (m_pt > HOLD && (m_pt - HOLD) % REP == 0)) begin
            m_pls = 1'b1;
            m_held = 1'b1;
          end
        end
      end else begin
        m_run++;
        if (m_run == DEB) begin
          m_lvl = m_s2;
          m_run = 0;
          if (m_lvl) begin
            m_pls = 1'b1;
            m_pt = 0;
          end else begin
            m_held = 1'b0;
          end
        end
      end
      m_s2 = m_s1;
      m_s1 = r;
    end
    e.step = step;
    e.lvl = m_lvl;
    e.pls = m_pls;
    e.hld = m_held;
    expq.push_back(e);
    step++;
  endtask

  task automatic hold_level(input logic r, input int n);
    for (int i = 0; i < n; i++) drive(r, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    logic prev_p;
    prev_p = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        total++;
        if ({button_level, button_pulse, button_held} !== {e.lvl, e.pls, e.hld}) begin
          bad++;
          $display("FAIL outputs step=%0d got lvl/pls/hld=%b%b%b expected %b%b%b",
                   e.step, button_level, button_pulse, button_held, e.lvl, e.pls, e.hld);
        end
        total++;
        if (button_pulse === 1'b1 && prev_p === 1'b1) begin
          bad++;
          $display("FAIL double_pulse step=%0d got two consecutive pulses expected one", e.step);
        end
        if (button_pulse === 1'b1) pulse_log.push_back(e.step);
        prev_p = button_pulse;
      end
    end
  end

  int ex[$];

  task automatic check_pulses(input string name, input int lo, input int hi);
    int got[$];
    foreach (pulse_log[i]) if (pulse_log[i] >= lo && pulse_log[i] <= hi) got.push_back(pulse_log[i]);
    total++;
    if (got.size() != ex.size()) begin
      bad++;
      $display("FAIL %s pulse count got %0d expected %0d", name, got.size(), ex.size());
    end else begin
      foreach (ex[i]) begin
        total++;
        if (got[i] != ex[i]) begin
          bad++;
          $display("FAIL %s pulse %0d at step %0d expected step %0d", name, i, got[i], ex[i]);
        end
      end
    end
  endtask

  initial begin : driver
    int s0;
    int r;
    int lo;
    logic lv;
    int nb;
    int ns;

    // Reset and idle
    drive(1'b0, 1'b1);
    lo = step;
    hold_level(1'b0, 50);
    ex.delete();
    check_pulses("idle", lo, step - 2);

    // Clean press, hold, repeat, release
    s0 = step;
    hold_level(1'b1, 62);
    hold_level(1'b0, 10);
    ex.delete();
    ex.push_back(s0 + 5);  ex.push_back(s0 + 25); ex.push_back(s0 + 33);
    ex.push_back(s0 + 41); ex.push_back(s0 + 49); ex.push_back(s0 + 57);
    check_pulses("hold_repeat", s0, step - 2);

    // Bounce pattern 1,1,0,1,1,1,0,1 then steady
    s0 = step;
    drive(1'b1, 1'b0); drive(1'b1, 1'b0); drive(1'b0, 1'b0); drive(1'b1, 1'b0);
    drive(1'b1, 1'b0); drive(1'b1, 1'b0);
    lo = step;
    drive(1'b0, 1'b0);
    hold_level(1'b1, 13);
    hold_level(1'b0, 10);
    ex.delete();
    ex.push_back(lo + 6);
    check_pulses("bounce", s0, step - 2);

    // Release glitch of two low samples
    s0 = step;
    hold_level(1'b1, 15);
    hold_level(1'b0, 2);
    hold_level(1'b1, 20);
    hold_level(1'b0, 10);
    ex.delete();
    ex.push_back(s0 + 5); ex.push_back(s0 + 27); ex.push_back(s0 + 35);
    check_pulses("glitch", s0, step - 2);

    // Reset during debounce with the button still held
    s0 = step;
    hold_level(1'b1, 3);
    r = step;
    drive(1'b1, 1'b1);
    hold_level(1'b1, 10);
    hold_level(1'b0, 10);
    ex.delete();
    ex.push_back(r + 6);
    check_pulses("reset_press_wait", s0, step - 2);

    // Reset during auto-repeat with the button still held
    s0 = step;
    hold_level(1'b1, 35);
    r = step;
    drive(1'b1, 1'b1);
    hold_level(1'b1, 10);
    hold_level(1'b0, 10);
    ex.delete();
    ex.push_back(s0 + 5); ex.push_back(s0 + 25); ex.push_back(s0 + 33); ex.push_back(r + 6);
    check_pulses("reset_repeat", s0, step - 2);

    // Random bounce segments
    for (int seg = 0; seg < 80; seg++) begin
      lv = 1'($urandom_range(0, 1));
      nb = $urandom_range(0, 6);
      ns = $urandom_range(1, 45);
      if ($urandom_range(0, 19) == 0) drive(lv, 1'b1);
      for (int i = 0; i < nb; i++) drive(1'($urandom_range(0, 1)), 1'b0);
      hold_level(lv, ns);
    end
    hold_level(1'b0, 10);

    for (int i = 0; i < 5; i++) begin
      if (expq.size() == 0) break;
      @(posedge clk);
      #2;
    end
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL drain got %0d pending expected 0", expq.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and reset.
REQ-002 Parameter DEBOUNCE_CYCLES, default 16, SHALL set the number of consecutive stable synchronized samples required to accept a level change; legal range 2..2^CNT_W-1.
REQ-003 Parameter HOLD_CYCLES, default 50000, SHALL set the number of PRESSED cycles after the first pulse before auto-repeat starts.
REQ-004 Parameter REPEAT_CYCLES, default 10000, SHALL set the auto-repeat pulse interval.
REQ-005 Parameter REPEAT_EN, default 1, SHALL enable auto-repeat; 0 disables repeat pulses and keeps button_held at 0.
REQ-006 Parameter CNT_W, default 17, SHALL set the counter width; it SHALL hold the largest of the three cycle parameters.
REQ-007 clk  input  1  system clock; all state changes on the rising edge.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 button_raw  input  1  asynchronous, bouncing push-button level; 1 = pressed.
REQ-010 button_level  output  1  debounced, registered button level.
REQ-011 button_pulse  output  1  one-cycle strobe for an accepted press or an auto-repeat; feeds the display driver's button input.
REQ-012 button_held  output  1  high while auto-repeat is active.

Function
REQ-013 button_raw SHALL pass through a two-flop synchronizer (s1, s2) before any other logic uses it; only s2 SHALL drive the FSM.
REQ-014 The FSM SHALL have exactly four states: IDLE, PRESS_WAIT, PRESSED and RELEASE_WAIT.
REQ-015 IDLE: s2=1 -> PRESS_WAIT with stable counter=1; s2=0 -> stay in IDLE.
REQ-016 PRESS_WAIT: s2=0 -> IDLE with counter=0 and no output change; s2=1 -> counter+1; on the edge where s2=1 and counter=DEBOUNCE_CYCLES-1 -> PRESSED, button_level=1, button_pulse=1 for one cycle, hold counter=0.
REQ-017 Press latency: if button_raw is first sampled high at edge 0 and stays high, button_pulse and button_level SHALL become 1 after edge DEBOUNCE_CYCLES+1.
REQ-018 PRESSED: s2=0 -> RELEASE_WAIT with stable counter=1; otherwise the hold counter increments each cycle.
REQ-019 With REPEAT_EN=1, PRESSED SHALL pulse when the hold counter reaches HOLD_CYCLES, then every REPEAT_CYCLES cycles; button_held SHALL be 1 from the first repeat pulse until release is accepted.
REQ-020 The hold and repeat counters SHALL saturate and never wrap.
REQ-021 RELEASE_WAIT: s2=1 -> PRESSED with no pulse, and the hold counter resumes from its frozen value; s2=0 -> counter+1; at DEBOUNCE_CYCLES consecutive lows -> IDLE with button_level=0 and button_held=0.
REQ-022 Release SHALL never generate a pulse.
REQ-023 button_pulse SHALL never be high on two consecutive cycles.
REQ-024 All outputs SHALL be registered, with no combinational path from button_raw.

Reset
REQ-025 When reset=1 at a rising edge, the block SHALL set s1=0, s2=0, state=IDLE, all counters=0 and button_level=button_pulse=button_held=0, regardless of state.
REQ-026 A reset asserted mid-press SHALL discard any partial count; if button_raw stays high after reset, a new full debounce and a new pulse SHALL follow.
REQ-027 The first FSM evaluation after reset SHALL use s2=0, so no pulse can occur within 2 cycles of reset deassertion.

Verification (DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8, REPEAT_EN=1)
REQ-028 Reset: pulse reset 1 cycle with button_raw=0 -> all outputs 0; 50 idle cycles -> no pulse.
REQ-029 Clean press: button_raw rises and is sampled at edge 0, then held -> button_pulse=1 only in the cycle after edge 5; button_level=1 from then on.
REQ-030 Bounce: button_raw pattern 1,1,0,1,1,1,0,1 then steady 1 -> no pulse during the pattern; exactly one pulse 4 consecutive s2 highs after the last low.
REQ-031 Hold/repeat: press held 60 cycles past the first pulse -> pulses at +0, +20, +28, +36, +44, +52 cycles; button_held=1 from +20; on release, button_level and button_held fall after 4 stable lows with no extra pulse.
REQ-032 Release glitch: while PRESSED, button_raw low for 2 cycles then high -> button_level stays 1, no pulse, and the repeat schedule shifts by exactly the glitch cycles spent in RELEASE_WAIT.
REQ-033 Reset mid-operation: reset during PRESS_WAIT and during auto-repeat with button_raw held 1 -> outputs 0 immediately; the next pulse arrives DEBOUNCE_CYCLES+2 edges after reset deasserts.
